// File: rtl/if_id_skid_reg_pkg.sv
// Package: if_id_skid_reg_pkg
// Shared definitions for the IF/ID skid register slice: default widths,
// the NOP pattern, the MIPS opcodes that matter to the sign-extend select,
// and the occupancy state encoding.
package if_id_skid_reg_pkg;

  localparam int          DW_DEF        = 32;
  localparam int          AW_DEF        = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Arithmetic, compare, memory-offset and branch-offset immediates are
  // sign-extended; logical immediates, lui and R-type are not.
  function automatic logic opcode_sext(input logic [5:0] op);
    logic s;
    s = 1'b0;
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE:            s = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_RTYPE:                                s = 1'b0;
      default:                                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Interface: if_id_skid_reg_if
// One valid/ready stream carrying an instruction and its PC+4.
//   valid  beat present (master -> slave)
//   ready  slave can accept (slave -> master)
//   instr  instruction, DW bits
//   pc4    PC+4, AW bits
interface if_id_skid_reg_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc4;

  modport master (output valid, output instr, output pc4, input ready);
  modport slave  (input valid, input instr, input pc4, output ready);
endinterface

// File: rtl/if_id_skid_reg_sext_decode.sv
// Module: sext_decode
// Combinational opcode -> sign-extend select for the ext unit. Kept as its
// own module so the ID control unit can instantiate the same decode.
//   opcode  in   6  instruction bits [31:26]
//   sext    out  1  1 = sign-extend imm16, 0 = zero-extend
module sext_decode
  import if_id_skid_reg_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       sext
);

  assign sext = opcode_sext(opcode);

endmodule

// File: rtl/if_id_skid_reg.sv
// Module: if_id_skid_reg
// IF/ID pipeline register built as a 2-entry skid buffer. The main register
// drives decode; the skid register catches the beat that arrives while
// decode stalls, so if_ready can be a flop.
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous flush (taken jump/branch), highest priority
//   if_bus    slave  stream from fetch (valid/ready/instr/pc4)
//   id_bus    master stream to decode; instr is NOP_INSTR while !valid
//   id_shamt  out  id_instr[10:6]
//   id_imm16  out  id_instr[15:0]
//   id_sext   out  sign-extend select for imm16
//
// state     | meaning
// OCC_EMPTY | nothing held, id_valid=0
// OCC_ONE   | main holds the head beat, skid empty
// OCC_TWO   | main holds head, skid holds next beat; fetch is stalled
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int          DW        = DW_DEF,
  parameter int          AW        = AW_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  if_id_skid_reg_if.slave    if_bus,
  if_id_skid_reg_if.master   id_bus,
  output logic [4:0]         id_shamt,
  output logic [15:0]        id_imm16,
  output logic               id_sext
);

  occ_e          state_q, state_d;
  logic          if_ready_q;
  logic          in_xfer, out_xfer;
  logic          load_main, load_skid, skid_to_main;
  logic          id_valid;
  logic [DW-1:0] main_instr, skid_instr, id_instr;
  logic [AW-1:0] main_pc4, skid_pc4;

  assign id_valid = (state_q != OCC_EMPTY);
  assign in_xfer  = if_bus.valid & if_ready_q;
  assign out_xfer = id_valid & id_bus.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      if_ready_q <= (state_d != OCC_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (in_xfer) state_d = OCC_ONE;
        OCC_ONE: begin
          if (in_xfer && !out_xfer)      state_d = OCC_TWO;
          else if (out_xfer && !in_xfer) state_d = OCC_EMPTY;
        end
        OCC_TWO:   if (out_xfer) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // Payload load strobes. A flushed cycle loads nothing, so the dropped
  // beat never lands in either register.
  always_comb begin
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (!flush) begin
      case (state_q)
        OCC_EMPTY: load_main = in_xfer;
        OCC_ONE: begin
          load_main = in_xfer & out_xfer;
          load_skid = in_xfer & ~out_xfer;
        end
        OCC_TWO:   skid_to_main = out_xfer;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_instr <= '0;
      main_pc4   <= '0;
    end else if (load_main) begin
      main_instr <= if_bus.instr;
      main_pc4   <= if_bus.pc4;
    end else if (skid_to_main) begin
      main_instr <= skid_instr;
      main_pc4   <= skid_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else if (load_skid) begin
      skid_instr <= if_bus.instr;
      skid_pc4   <= if_bus.pc4;
    end
  end

  assign id_instr     = id_valid ? main_instr : DW'(NOP_INSTR);
  assign if_bus.ready = if_ready_q;
  assign id_bus.valid = id_valid;
  assign id_bus.instr = id_instr;
  assign id_bus.pc4   = main_pc4;
  assign id_shamt     = id_instr[10:6];
  assign id_imm16     = id_instr[15:0];

  sext_decode u_sext_decode (
    .opcode (id_instr[31:26]),
    .sext   (id_sext)
  );

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [4:0]  id_shamt;
  logic [15:0] id_imm16;
  logic        id_sext;

  int checks   = 0;
  int failures = 0;

  beat_t q[$];
  logic [5:0] op_tab [0:15];

  if_id_skid_reg_if #(.DW(32), .AW(32)) fbus ();
  if_id_skid_reg_if #(.DW(32), .AW(32)) dbus ();

  if_id_skid_reg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .if_bus   (fbus),
    .id_bus   (dbus),
    .id_shamt (id_shamt),
    .id_imm16 (id_imm16),
    .id_sext  (id_sext)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sext: listed directly from the opcode table of the ISA.
  function automatic logic ref_sext(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    return (op == 6'h08) || (op == 6'h09) || (op == 6'h0A) || (op == 6'h0B) ||
           (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
  endfunction

  task automatic check_outputs();
    logic [31:0] ei;
    ei = (q.size() != 0) ? q[0].instr : 32'h0;
    chk("id_valid", 64'(dbus.valid), 64'(q.size() != 0));
    chk("if_ready", 64'(fbus.ready), 64'(q.size() < 2));
    chk("id_instr", 64'(dbus.instr), 64'(ei));
    if (q.size() != 0) chk("id_pc4", 64'(dbus.pc4), 64'(q[0].pc4));
    chk("id_shamt", 64'(id_shamt), 64'((ei >> 6) & 32'h1F));
    chk("id_imm16", 64'(id_imm16), 64'(ei & 32'hFFFF));
    chk("id_sext", 64'(id_sext), 64'(ref_sext(ei)));
  endtask

  // One clock: drive at the falling edge, update the queue model at the
  // rising edge, check at the next falling edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic rdy, input logic fl);
    bit acc, pop;
    fbus.valid = v;
    fbus.instr = ins;
    fbus.pc4   = p;
    dbus.ready = rdy;
    flush      = fl;
    acc = v && (q.size() < 2);
    pop = rdy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{instr: ins, pc4: p});
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int accepted;
    int cycles;
    bit acc;
    logic [31:0] ri;

    op_tab[0] = 6'h00; op_tab[1] = 6'h04; op_tab[2] = 6'h05; op_tab[3] = 6'h08;
    op_tab[4] = 6'h09; op_tab[5] = 6'h0A; op_tab[6] = 6'h0B; op_tab[7] = 6'h0C;
    op_tab[8] = 6'h0D; op_tab[9] = 6'h0E; op_tab[10] = 6'h0F; op_tab[11] = 6'h23;
    op_tab[12] = 6'h2B; op_tab[13] = 6'h02; op_tab[14] = 6'h03; op_tab[15] = 6'h20;

    rst_n = 1'b0;
    flush = 1'b0;
    fbus.valid = 1'b0;
    fbus.instr = 32'h0;
    fbus.pc4   = 32'h0;
    dbus.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_id_valid", 64'(dbus.valid), 64'd0);
    chk("rst_id_instr", 64'(dbus.instr), 64'd0);
    chk("rst_id_pc4", 64'(dbus.pc4), 64'd0);
    chk("rst_if_ready", 64'(fbus.ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // single beat: sll with shamt 24
    step(1'b1, 32'h0000_0600, 32'd4, 1'b1, 1'b0);
    chk("t2_valid", 64'(dbus.valid), 64'd1);
    chk("t2_shamt", 64'(id_shamt), 64'h18);
    chk("t2_sext", 64'(id_sext), 64'd0);
    chk("t2_pc4", 64'(dbus.pc4), 64'd4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // stall: two beats fill the buffer
    step(1'b1, 32'h2008_FFFF, 32'd8, 1'b0, 1'b0);
    step(1'b1, 32'h8C09_0004, 32'd12, 1'b0, 1'b0);
    chk("t3_if_ready", 64'(fbus.ready), 64'd0);
    chk("t3_imm0", 64'(id_imm16), 64'hFFFF);
    chk("t3_sext0", 64'(id_sext), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t3_imm1", 64'(id_imm16), 64'h0004);
    chk("t3_sext1", 64'(id_sext), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t3_drained", 64'(dbus.valid), 64'd0);

    // flush while full, with a beat offered on the same edge
    step(1'b1, 32'h3C01_1234, 32'd16, 1'b0, 1'b0);
    step(1'b1, 32'h3421_5678, 32'd20, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 32'd24, 1'b0, 1'b1);
    chk("t4_valid", 64'(dbus.valid), 64'd0);
    chk("t4_if_ready", 64'(fbus.ready), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t4_no_ghost", 64'(dbus.valid), 64'd0);

    // streaming: 8 beats, no bubbles
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 32'h2000_0000 + 32'(k), 32'(4 * k), 1'b1, 1'b0);
      chk("t5_valid", 64'(dbus.valid), 64'd1);
      chk("t5_pc4", 64'(dbus.pc4), 64'(4 * k));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset mid-stream
    step(1'b1, 32'h2400_0001, 32'd40, 1'b0, 1'b0);
    step(1'b1, 32'h2400_0002, 32'd44, 1'b0, 1'b0);
    fbus.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("t1_async_valid", 64'(dbus.valid), 64'd0);
    chk("t1_async_instr", 64'(dbus.instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_if_ready", 64'(fbus.ready), 64'd1);
    check_outputs();

    // random traffic against the queue model
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      ri = {op_tab[$urandom_range(0, 15)], 26'($urandom)};
      acc = ($urandom_range(0, 99) < 70) && (q.size() < 2);
      if (acc) begin
        step(1'b1, ri, $urandom, ($urandom_range(0, 99) < 60), 1'b0);
        accepted++;
      end else begin
        step(($urandom_range(0, 99) < 70), ri, $urandom,
             ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 2));
      end
      cycles++;
    end
    chk("t6_budget", 64'(accepted >= 1000), 64'd1);
    cycles = 0;
    while (q.size() != 0 && cycles < 10) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycles++;
    end
    chk("t6_drain", 64'(dbus.valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
